// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier with signed/unsigned modes.
// One operand bit per cycle; a registered done pulse follows the cycle that writes hi/lo.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;
  logic               w_last;
  logic               w_busy;
  logic               w_done_nxt;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (sign && b[WIDTH-1]) ? -b : b;
  assign w_sum   = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod  = {w_sum, r_mplier[WIDTH-1:1]};
  assign w_res   = r_neg ? -w_prod : w_prod;
  assign w_last  = (r_cnt == CntW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != StIdle);
    w_done_nxt = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_done_nxt;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= CntW'(WIDTH);
          end
        end
        StRun: begin
          r_acc    <= {1'b0, w_sum[WIDTH:1]};
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - CntW'(1);
          if (w_last) begin
            {r_hi, r_lo} <= w_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: scoreboard of expected products, latency/busy/done-pulse checks,
// ignored-start, operand-change, and asynchronous-reset-abort scenarios.
module tb_mult_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  mult_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sign    (sign),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'({32'b0, x}) * longint'({32'b0, y});
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge 40 cycles after the capturing edge.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input int inject_idx);
    int busy_cnt;
    int done_cnt;
    int first_done;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = -1;
    a     = x;
    b     = y;
    sign  = s;
    start = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sign  = 1'($urandom_range(0, 1));
    for (int k = 0; k < 40; k++) begin
      if (k == inject_idx) begin
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
      end
      if (k == inject_idx + 1) start = 1'b0;
      if (k == 10) check("hold_during_run", {hi, lo}, last_exp);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          check("product", {hi, lo}, last_exp);
        end
      end
      @(negedge clk);
    end
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("done_latency", 64'(first_done), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int done_seen;
    n_cmp    = 0;
    n_bad    = 0;
    last_exp = '0;
    reset_n  = 1'b0;
    start    = 1'b0;
    sign     = 1'b0;
    a        = '0;
    b        = '0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(32'd3, 32'd5, 1'b0, -1);
    check("u3x5_hi", 64'(hi), 64'h0);
    check("u3x5_lo", 64'(lo), 64'hF);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    check("umax_hi", 64'(hi), 64'hFFFF_FFFE);
    check("umax_lo", 64'(lo), 64'h1);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
    check("sneg1_hi", 64'(hi), 64'h0);
    check("sneg1_lo", 64'(lo), 64'h1);

    do_op(32'h8000_0000, 32'd2, 1'b1, -1);
    check("smin_hi", 64'(hi), 64'hFFFF_FFFF);
    check("smin_lo", 64'(lo), 64'h0);

    do_op(32'd0, 32'h8000_0000, 1'b1, -1);
    check("szero_hi", 64'(hi), 64'h0);
    check("szero_lo", 64'(lo), 64'h0);

    // Second start during RUN must be dropped.
    do_op(32'd7, 32'd6, 1'b0, 9);
    check("ign_lo", 64'(lo), 64'h2A);
    check("ign_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      do_op($urandom, $urandom, 1'(i), -1);
    end

    do_op(32'd4, 32'd4, 1'b0, -1);
    check("u4x4_lo", 64'(lo), 64'h10);

    // Start 9x9, then reset mid-RUN between clock edges.
    a     = 32'd9;
    b     = 32'd9;
    sign  = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(32'd9, 32'd9, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    exp_q.delete();
    last_exp  = '0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 3) reset_n = 1'b1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    do_op(32'd2, 32'd3, 1'b0, -1);
    check("post_rst_lo", 64'(lo), 64'h6);
    check("post_rst_hi", 64'(hi), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; hi and lo are each WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port sign, input, 1 bit: 1 = signed two's-complement multiply (mult); 0 = unsigned (multu); sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo updated.
REQ-010 SHALL have port hi, output, WIDTH bits: upper half of the 2*WIDTH-bit product.
REQ-011 SHALL have port lo, output, WIDTH bits: lower half of the 2*WIDTH-bit product.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, SHALL capture a, b and sign at that edge and go to RUN; in IDLE with start=0, SHALL stay in IDLE.
REQ-014 On capture with sign=1, SHALL register |a|, |b| and neg = a[MSB] XOR b[MSB]; with sign=0, SHALL register a and b unchanged and neg=0.
REQ-015 On capture, SHALL clear the WIDTH+1-bit accumulator and load iteration counter = WIDTH.
REQ-016 Each RUN cycle, SHALL perform one radix-2 shift-add step on the {accumulator, multiplier} register:
- if multiplier LSB = 1, add magnitude(a) to the accumulator (WIDTH+1 bits, carry kept);
- then shift the whole register right by 1;
- decrement the counter.
REQ-017 When the counter reaches 0 at the end of a RUN step, SHALL go to DONE; RUN therefore lasts exactly WIDTH cycles.
REQ-018 On entry to DONE, SHALL write the 2*WIDTH-bit product to {hi, lo}, two's-complement negated when neg=1.
REQ-019 In DONE, SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-020 SHALL set busy = 1 in RUN and DONE, and 0 in IDLE.
REQ-021 Latency: if start is sampled at edge N, done SHALL be high during the cycle following edge N+WIDTH+1 (cycle after edge N+33 for WIDTH=32); hi/lo SHALL be valid in that same cycle.
REQ-022 SHALL hold hi/lo stable from the DONE update until the next DONE; a new start SHALL NOT disturb hi/lo while RUN is in progress.
REQ-023 SHALL ignore start while busy=1; no queuing; the in-flight operation completes unaffected.
REQ-024 SHALL use captured operands only; changes on a, b and sign after capture SHALL have no effect.
REQ-025 SHALL always run the full WIDTH iterations; there is no early termination for zero or small operands.
REQ-026 With sign=1 and an operand of 0x80000000, SHALL produce the correct result: the magnitude 2^31 fits the unsigned path.
REQ-027 SHALL be free of combinational paths from inputs to outputs; all outputs come from registers.

Reset
REQ-028 reset_n=0 SHALL immediately, regardless of clk, force: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator and operand registers=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; hi/lo read 0.
REQ-030 After reset_n deasserts, the first start sampled SHALL begin a fresh operation with normal latency.

Verification
REQ-031 Bench SHALL cover: unsigned a=3, b=5, start one cycle -> done exactly one cycle at edge+33; hi=0x00000000, lo=0x0000000F; busy high for 33 cycles.
REQ-032 Bench SHALL cover: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Bench SHALL cover: signed 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> hi=0x00000000, lo=0x00000001; signed 0x80000000 x 0x00000002 -> hi=0xFFFFFFFF, lo=0x00000000.
REQ-034 Bench SHALL cover: start with 7 x 6, then start again with 2 x 2 at cycle 10 of RUN and change a/b -> single done pulse with lo=0x0000002A; second start ignored; busy low afterwards.
REQ-035 Bench SHALL cover: complete 4 x 4 (lo=0x10), start 9 x 9, assert reset_n=0 at RUN cycle 20 between clock edges -> busy, done, hi, lo go 0 immediately; no done pulse; after release, 2 x 3 -> lo=0x6 at normal latency.
REQ-036 Bench SHALL cover: signed 0 x 0x80000000 -> hi=0, lo=0, with no negative zero (neg=1 case still yields all zeros).
